// File: rtl/alu_seq_unit.sv
// Registered ALU with a valid/ready request port and a held result port.
// Single-cycle logic/arithmetic ops plus iterative shift-left and shift-add multiply.
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  // Handshake: a request transfers on a rising edge where in_valid & in_ready;
  // a result transfers on a rising edge where out_valid & out_ready. Once
  // raised, out_valid and the result stay stable until out_ready is seen.

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   bop;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   fast_res;
  logic               fast_carry;
  logic               fast_ovf;
  logic [WIDTH-1:0]   sh_step;
  logic [2*WIDTH-1:0] acc_step;
  logic [SHW-1:0]     amt;

  // Single adder serves ADD and SUB: SUB adds ~B with carry-in 1, so a
  // missing carry-out is a borrow.
  always_comb begin
    bop        = (FS == OP_SUB) ? ~B : B;
    sum        = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, (FS == OP_SUB)};
    fast_res   = sum[WIDTH-1:0];
    fast_carry = 1'b0;
    fast_ovf   = 1'b0;
    case (FS)
      OP_ADD: begin
        fast_carry = sum[WIDTH];
        fast_ovf   = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        fast_carry = ~sum[WIDTH];
        fast_ovf   = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  fast_res = A & B;
      OP_OR:   fast_res = A | B;
      OP_XOR:  fast_res = A ^ B;
      OP_NOT:  fast_res = ~A;
      default: fast_res = A;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    amt      = B[SHW-1:0];
    sh_step  = sh_q << 1;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = FS;
          if (FS <= OP_NOT || (FS == OP_SHL && amt == '0)) begin
            out_d   = fast_res;
            zero_d  = (fast_res == '0);
            carry_d = fast_carry;
            ovf_d   = fast_ovf;
            state_d = DONE;
          end else if (FS == OP_SHL) begin
            sh_d    = A;
            cnt_d   = CW'(amt);
            state_d = BUSY;
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            cnt_d    = CW'(WIDTH);
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_SHL) begin
          sh_d = sh_step;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        // The step computed this cycle is the final one: register it as the result.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          ovf_d   = 1'b0;
          if (op_q == OP_SHL) begin
            out_d   = sh_step;
            zero_d  = (sh_step == '0);
            carry_d = 1'b0;
          end else begin
            out_d   = acc_step[WIDTH-1:0];
            zero_d  = (acc_step[WIDTH-1:0] == '0);
            carry_d = |acc_step[2*WIDTH-1:WIDTH];
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out        = out_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit at WIDTH=16: directed vector table, randomized ops
// against an arithmetic reference model, and hold/reset corner sequences.
module tb_alu_seq_unit;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   FS;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero_flag;
  logic         carry_flag;
  logic         ovf_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   fs;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    int           lat;
  } vec_t;

  vec_t vt[16];
  logic [W+2:0] exp_q[$];
  int           lat_q[$];

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .FS(FS), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero_flag(zero_flag), .carry_flag(carry_flag), .ovf_flag(ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from the operation definitions, using plain integer arithmetic.
  function automatic vec_t model(input logic [2:0] fs, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t r;
    int unsigned ua, ub, full;
    int sa, sb, sd;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r.fs = fs; r.a = a; r.b = b; r.c = 0; r.v = 0; r.lat = 1;
    full = 0;
    case (fs)
      3'd0: begin full = ua + ub; sd = sa + sb; r.c = (full > 32'hFFFF); r.v = (sd > 32767 || sd < -32768); end
      3'd1: begin full = ua - ub; sd = sa - sb; r.c = (ua < ub); r.v = (sd > 32767 || sd < -32768); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: full = ~ua;
      3'd6: begin full = ua << (ub % W); r.lat = int'(ub % W) + 1; end
      default: begin full = ua * ub; r.c = (full > 32'hFFFF); r.lat = W + 1; end
    endcase
    r.res = full[W-1:0];
    r.z = (r.res == 0);
    return r;
  endfunction

  task automatic push_exp(input vec_t e);
    exp_q.push_back({e.res, e.z, e.c, e.v});
    lat_q.push_back(e.lat);
  endtask

  // Issue one op, measure edges from the accept edge to out_valid, check
  // against the head of the scoreboard, then complete the result handshake.
  task automatic do_op(input logic [2:0] fs, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int n;
    int lat;
    logic [W+2:0] e;
    int el;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    in_valid = 1; FS = fs; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 0; FS = 3'($urandom); A = W'($urandom); B = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    check({name, "_lat"}, lat, el);
    check({name, "_res"}, {out, zero_flag, carry_flag, ovf_flag}, e);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    logic [W-1:0] hold_out;
    logic [2:0]   hold_flags;
    logic         stable_ok;
    vec_t         m;

    vt[0]  = '{3'd0, 16'h29CB, 16'h29CB, 16'h5396, 1'b0, 1'b0, 1'b0, 1};
    vt[1]  = '{3'd1, 16'h29CB, 16'h29CB, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vt[2]  = '{3'd2, 16'h29CB, 16'h29CB, 16'h29CB, 1'b0, 1'b0, 1'b0, 1};
    vt[3]  = '{3'd3, 16'h29CB, 16'h29CB, 16'h29CB, 1'b0, 1'b0, 1'b0, 1};
    vt[4]  = '{3'd4, 16'h29CB, 16'h29CB, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vt[5]  = '{3'd5, 16'h29CB, 16'h29CB, 16'hD634, 1'b0, 1'b0, 1'b0, 1};
    vt[6]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1};
    vt[7]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1};
    vt[8]  = '{3'd7, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 17};
    vt[9]  = '{3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17};
    vt[10] = '{3'd6, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 5};
    vt[11] = '{3'd6, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    vt[12] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    vt[13] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1};
    vt[14] = '{3'd6, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 16};
    vt[15] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 17};

    rst_n = 0; in_valid = 0; out_ready = 0; FS = 0; A = 0; B = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, out, zero_flag, carry_flag, ovf_flag}, {1'b1, 1'b0, 16'h0, 3'b000});
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      push_exp(vt[i]);
      do_op(vt[i].fs, vt[i].a, vt[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_idle", i), in_ready, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   rfs;
      logic [W-1:0] ra, rb;
      rfs = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) ra = (i % 8 == 0) ? 16'h8000 : 16'hFFFF;
      push_exp(model(rfs, ra, rb));
      do_op(rfs, ra, rb, $sformatf("rnd%0d", i));
    end

    // Held result with back-pressure; competing requests must be ignored.
    in_valid = 1; FS = 3'd7; A = 16'h0003; B = 16'h0005;
    @(posedge clk); #1;
    in_valid = 0;
    for (int n = 0; n < 40 && !out_valid; n++) begin @(posedge clk); #1; end
    check("hold_valid", out_valid, 1'b1);
    hold_out = out; hold_flags = {zero_flag, carry_flag, ovf_flag};
    check("hold_res", {hold_out, hold_flags}, {16'h000F, 3'b000});
    stable_ok = 1;
    in_valid = 1; FS = 3'd0; A = 16'h1234; B = 16'h1111;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (out !== hold_out || {zero_flag, carry_flag, ovf_flag} !== hold_flags ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 0;
    end
    check("hold_stable", stable_ok, 1'b1);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("hold_release_idle", {in_ready, out_valid}, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_req", {in_ready, out_valid}, 2'b10);
    check("retain_after_idle", {out, zero_flag, carry_flag, ovf_flag}, {16'h000F, 3'b000});

    // Reset in the middle of a multiply.
    in_valid = 1; FS = 3'd7; A = 16'hFFFF; B = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_mul_busy", {in_ready, out_valid}, 2'b00);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("mid_mul_reset", {in_ready, out_valid, out, zero_flag, carry_flag, ovf_flag}, {1'b1, 1'b0, 16'h0, 3'b000});
    repeat (20) @(posedge clk);
    #1;
    check("reset_discard", {in_ready, out_valid}, 2'b10);

    m = model(3'd7, 16'h0012, 16'h0034);
    push_exp(m);
    do_op(3'd7, 16'h0012, 16'h0034, "post_reset_mul");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
